// File: rtl/xpmwrap_pkg.sv
// Shared constants and the read-response record for the TDP RAM arbiter.
package xpmwrap_pkg;

    // Port A read latency of the attached RAM (address stage + output register)
    localparam int RAM_RD_LATENCY = 2;

    // Response record is sized for the largest supported configuration
    // (8 requesters, 64-bit words); users zero-extend into it and slice out.
    localparam int RSP_ID_W   = 3;
    localparam int RSP_DATA_W = 64;

    typedef struct packed {
        logic [RSP_ID_W-1:0]   id;
        logic [RSP_DATA_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/xpmwrap_tdpram_arb_if.sv
// Requester and read-response bus between clients and the TDP RAM arbiter.
interface xpmwrap_tdpram_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rdata
    );

endinterface

// File: rtl/xpmwrap_sync_fifo.sv
// Synchronous response FIFO with a registered head entry and occupancy count.
module xpmwrap_sync_fifo
    import xpmwrap_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  rsp_t                   din_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output rsp_t                   dout_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    rsp_t          mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic          valid_q, valid_d;
    rsp_t          head_q, head_d;
    logic          do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_pop  = pop_i && valid_q;
    assign do_push = push_i && ((count_q < (PW+1)'(DEPTH)) || do_pop);

    // Next pointers, count and head entry; a push into an otherwise empty FIFO bypasses to the head
    always_comb begin
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        valid_d = (count_d != '0);
        head_d  = head_q;
        if (do_push && ((count_q - (PW+1)'(do_pop)) == '0)) begin
            head_d = din_i;
        end else if (valid_d) begin
            head_d = mem_q[rptr_d];
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    // Control state and head register; head clears so outputs read zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end

    assign valid_o = valid_q;
    assign dout_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/xpmwrap_tdpram_arb.sv
// Round-robin arbiter sharing RAM port A among NUM_REQ requesters; reads are
// credit-limited so their responses always fit in the response FIFO.
module xpmwrap_tdpram_arb
    import xpmwrap_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    xpmwrap_tdpram_arb_if.slave   bus,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic                  ram_regce,
    output logic                  ram_rst,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int TAG_N = RAM_RD_LATENCY + 1;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    logic [NUM_REQ-1:0]    eligible;
    logic                  grant_vld, accept, acc_read, credit_ok;
    logic [ID_W-1:0]       grant_idx, ptr_q, ptr_d;
    logic [CNT_W-1:0]      fifo_count, inflight_q, inflight_d;
    logic [CNT_W:0]        credit_sum;
    logic                  ram_en_q, ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_din_q;
    logic [TAG_N-1:0]      tag_vld_q;
    logic [ID_W-1:0]       tag_id_q [TAG_N];
    logic                  fifo_valid, fifo_push, fifo_pop;
    rsp_t                  push_rsp, head_rsp;
    logic                  unused_head;

    // A read may only start if its response has a guaranteed FIFO slot
    assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign credit_ok  = credit_sum < (CNT_W+1)'(RSP_DEPTH);
    assign eligible   = bus.req_valid & (bus.req_we | {NUM_REQ{credit_ok}});

    // First eligible requester at or after the priority pointer wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && eligible[rr_index(ptr_q, i)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_index(ptr_q, i);
            end
        end
    end

    assign accept   = grant_vld && !rst;
    assign acc_read = accept && !bus.req_we[grant_idx];
    assign ptr_d    = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);

    // One-hot ready toward the granted requester only
    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_idx] = 1'b1;
    end

    // Issue strobes and priority pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            ptr_q    <= '0;
        end else begin
            ram_en_q <= accept;
            ram_we_q <= accept && bus.req_we[grant_idx];
            if (accept) ptr_q <= ptr_d;
        end
    end

    // Address and write data of the granted requester, qualified by ram_en
    always_ff @(posedge clk) begin
        ram_addr_q <= bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ram_din_q  <= bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Read tags follow the RAM pipeline so data and requester id meet at the FIFO
    always_ff @(posedge clk) begin
        if (rst) tag_vld_q <= '0;
        else     tag_vld_q <= {tag_vld_q[TAG_N-2:0], acc_read};
    end

    // Requester ids shadowing the tag valid bits
    always_ff @(posedge clk) begin
        tag_id_q[0] <= grant_idx;
        for (int i = 1; i < TAG_N; i++) tag_id_q[i] <= tag_id_q[i-1];
    end

    assign fifo_push = tag_vld_q[RAM_RD_LATENCY];
    assign fifo_pop  = bus.rsp_valid && bus.rsp_ready;

    // Reads issued but not yet landed in the FIFO
    always_comb begin
        inflight_d = inflight_q;
        if (acc_read && !fifo_push)      inflight_d = inflight_q + CNT_W'(1);
        else if (!acc_read && fifo_push) inflight_d = inflight_q - CNT_W'(1);
    end

    // In-flight read counter
    always_ff @(posedge clk) begin
        if (rst) inflight_q <= '0;
        else     inflight_q <= inflight_d;
    end

    // Returning RAM word paired with its requester id
    always_comb begin
        push_rsp      = '0;
        push_rsp.id   = RSP_ID_W'(tag_id_q[RAM_RD_LATENCY]);
        push_rsp.data = RSP_DATA_W'(ram_dout);
    end

    xpmwrap_sync_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (push_rsp),
        .pop_i   (fifo_pop),
        .valid_o (fifo_valid),
        .dout_o  (head_rsp),
        .count_o (fifo_count)
    );

    // Record fields beyond this configuration's widths are padding
    assign unused_head = ^head_rsp;

    assign bus.rsp_valid = fifo_valid && !rst;
    assign bus.rsp_id    = head_rsp.id[ID_W-1:0];
    assign bus.rsp_rdata = head_rsp.data[DATA_WIDTH-1:0];

    assign ram_en    = ram_en_q && !rst;
    assign ram_we    = ram_we_q && !rst;
    assign ram_regce = tag_vld_q[RAM_RD_LATENCY-1] && !rst;
    assign ram_rst   = rst;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

endmodule

// File: doc/xpmwrap_tdpram_arb.md
XPMWRAP_TDPRAM_ARB -- requirements
Module: xpmwrap_tdpram_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, RAM word-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-004 SHALL have parameter RSP_DEPTH, default 4, response FIFO depth (power of 2, >= 4).
REQ-005 clk  in  1  sole clock; one clock only, RAM driven in common_clock mode.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester request valid.
REQ-008 req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
REQ-009 req_we  in  NUM_REQ  1 = write, 0 = read.
REQ-010 req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-011 req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
REQ-012 rsp_valid / rsp_ready  out / in  1 each  read-response handshake.
REQ-013 rsp_id  out  $clog2(NUM_REQ)  requester that issued the read.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data.
REQ-015 ram_en, ram_we, ram_regce, ram_rst  out  1 each  to RAM port A.
REQ-016 ram_addr / ram_din  out  ADDR_WIDTH / DATA_WIDTH; ram_dout  in  DATA_WIDTH.

Function
REQ-017 Eligible requester: req_valid=1 and (req_we=1 or read credit available).
REQ-018 Arbitration SHALL be round-robin from priority pointer ptr; first eligible index at or after ptr (mod NUM_REQ) is granted.
REQ-019 req_ready SHALL be combinational, one-hot to granted requester, zero if none eligible.
REQ-020 On accept of index g, ptr SHALL become (g+1) mod NUM_REQ; otherwise ptr holds.
REQ-021 Accepted op SHALL be registered to RAM: ram_en=1, ram_we=req_we, ram_addr, ram_din in cycle T+1 for accept in cycle T; ram_en=0 and ram_we=0 otherwise.
REQ-022 RAM read latency is fixed at 2; ram_regce SHALL be 1 exactly in the cycle after a read issue (second pipeline stage).
REQ-023 A valid/id tag shift register SHALL track each read; ram_dout SHALL be pushed with its id into the response FIFO in cycle T+3.
REQ-024 Read accepted in cycle T with empty FIFO SHALL produce rsp_valid in cycle T+4.
REQ-025 Credit: reads eligible only when fifo_count + inflight < RSP_DEPTH; inflight +1 on read accept, -1 on FIFO push, unchanged on both in one cycle.
REQ-026 FIFO SHALL never overflow; rsp_valid, rsp_id, rsp_rdata SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-027 Pop and push in same cycle with full FIFO SHALL both succeed; count unchanged.
REQ-028 Writes SHALL never be blocked by credit; writes produce no response.
REQ-029 Responses SHALL be returned in accept order.
REQ-030 ram_rst SHALL equal rst.

Reset
REQ-031 During rst: req_ready=0, ram_en=0, ram_we=0, ram_regce=0, rsp_valid=0.
REQ-032 On rst: ptr=0, inflight=0, tag pipeline cleared, FIFO emptied; rsp_id and rsp_rdata SHALL be 0.
REQ-033 Reset mid-operation SHALL discard in-flight reads; no response for them after rst deasserts.

Structure
REQ-034 Package xpmwrap_pkg SHALL hold RAM read-latency constant (2) and the response struct {id, data}.
REQ-035 Response FIFO SHALL be sub-module xpmwrap_sync_fifo (synchronous, registered outputs, count output).
REQ-036 Top SHALL not instantiate the RAM; integration connects ram_* to xpmwrap_tdpram port A with READ_LATENCY_A=2.

Verification
REQ-037 Single read: req 1 reads addr 5 holding 0xDEADBEEF at cycle 0 -> rsp_valid cycle 4, rsp_id=1, rsp_rdata=0xDEADBEEF.
REQ-038 All 4 requesters hold valid continuously, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-039 rsp_ready=0, requester 0 streams reads -> exactly 4 accepted, then req_ready[0]=0; one pop -> exactly one more accept.
REQ-040 Credit exhausted, requester 2 write and requester 0 read valid -> write to requester 2 granted, read stalled.
REQ-041 Write 0x12345678 to addr 0x3F then read back -> rsp_rdata=0x12345678; no response for the write.
REQ-042 rst asserted cycle 2 after read accept at cycle 0 -> rsp_valid stays 0 through cycle 10, ptr=0.
